// File: rtl/i2c_wr_master.sv
// Write-only I2C master: sends a fixed 4-byte frame (addr+W, reg hi, reg lo, data)
// per four-phase req/ack handshake. SCL is built from quarter-period slots.
module i2c_wr_master #(
  parameter int QTR_DIV = 312
) (
  input  logic        clk_25M,
  input  logic        rst_100,
  input  logic [31:0] cfg_data,
  input  logic        i2c_req,
  output logic        i2c_ack,
  output logic        sclk,
  output logic        sda,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic        busy,
  output logic        nack
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACKS, STOP, DONE} state_t;

  state_t      state, n_state;
  logic [15:0] qcnt;
  logic [1:0]  qtr, n_qtr;
  logic [2:0]  bit_cnt, n_bit;
  logic [1:0]  byte_cnt, n_byte;
  logic [31:0] shreg, n_sh;
  logic        n_nack, n_sclk, n_sda, n_oe;
  logic        qend;

  assign qend = (qcnt == 16'(QTR_DIV - 1));

  always_comb begin
    n_state = state;
    n_qtr   = qtr;
    n_bit   = bit_cnt;
    n_byte  = byte_cnt;
    n_sh    = shreg;
    n_nack  = nack;
    case (state)
      IDLE: if (i2c_req) begin
        n_state = START;
        n_qtr   = 2'd0;
        n_bit   = 3'd0;
        n_byte  = 2'd0;
        n_sh    = cfg_data;
        n_nack  = 1'b0;
      end
      START: if (qend) begin
        if (qtr == 2'd1) begin
          n_state = BIT;
          n_qtr   = 2'd0;
        end else n_qtr = qtr + 2'd1;
      end
      BIT: if (qend) begin
        n_qtr = qtr + 2'd1;
        // Shift only at the end of q3 so SDA changes while SCL is low
        if (qtr == 2'd3) begin
          n_sh  = {shreg[30:0], 1'b0};
          n_bit = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) n_state = ACKS;
        end
      end
      ACKS: if (qend) begin
        n_qtr = qtr + 2'd1;
        if (qtr == 2'd2 && sda_in) n_nack = 1'b1;
        if (qtr == 2'd3) begin
          n_byte  = byte_cnt + 2'd1;
          n_state = (byte_cnt == 2'd3) ? STOP : BIT;
        end
      end
      STOP: if (qend) begin
        if (qtr == 2'd2) n_state = DONE;
        else n_qtr = qtr + 2'd1;
      end
      DONE: if (!i2c_req) n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  // Bus pins decoded from the upcoming state so they are registered with it
  always_comb begin
    n_sclk = 1'b1;
    n_sda  = 1'b1;
    n_oe   = 1'b1;
    case (n_state)
      START: begin
        n_sclk = (n_qtr == 2'd0);
        n_sda  = 1'b0;
      end
      BIT: begin
        n_sclk = (n_qtr == 2'd1) || (n_qtr == 2'd2);
        n_sda  = n_sh[31];
      end
      ACKS: begin
        n_sclk = (n_qtr == 2'd1) || (n_qtr == 2'd2);
        n_oe   = 1'b0;
      end
      STOP: begin
        n_sclk = (n_qtr != 2'd0);
        n_sda  = (n_qtr == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25M or negedge rst_100) begin
    if (!rst_100) begin
      state    <= IDLE;
      qcnt     <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      nack     <= 1'b0;
      sclk     <= 1'b1;
      sda      <= 1'b1;
      sda_oe   <= 1'b1;
      busy     <= 1'b0;
      i2c_ack  <= 1'b0;
    end else begin
      state    <= n_state;
      qcnt     <= (state == IDLE || state == DONE || qend) ? '0 : qcnt + 16'd1;
      qtr      <= n_qtr;
      bit_cnt  <= n_bit;
      byte_cnt <= n_byte;
      shreg    <= n_sh;
      nack     <= n_nack;
      sclk     <= n_sclk;
      sda      <= n_sda;
      sda_oe   <= n_oe;
      busy     <= (n_state == START) || (n_state == BIT) ||
                  (n_state == ACKS)  || (n_state == STOP);
      i2c_ack  <= (n_state == DONE);
    end
  end

endmodule

// File: tb/tb_i2c_wr_master.sv
// Directed bench for i2c_wr_master: bus monitor decodes bytes, ACK slots,
// START/STOP edges and SCL-high SDA glitches; slave model can NACK one slot.
module tb_i2c_wr_master;
  localparam int QTR = 4;
  localparam int ACK_CYC = 1 + 149 * QTR;

  logic        clk_25M = 1'b0;
  logic        rst_100;
  logic [31:0] cfg_data;
  logic        i2c_req;
  logic        i2c_ack, sclk, sda, sda_oe, sda_in, busy, nack;

  i2c_wr_master #(.QTR_DIV(QTR)) dut (
    .clk_25M (clk_25M),
    .rst_100 (rst_100),
    .cfg_data(cfg_data),
    .i2c_req (i2c_req),
    .i2c_ack (i2c_ack),
    .sclk    (sclk),
    .sda     (sda),
    .sda_oe  (sda_oe),
    .sda_in  (sda_in),
    .busy    (busy),
    .nack    (nack)
  );

  always #5 clk_25M = ~clk_25M;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor / slave model
  int        nack_slot;
  int        acks_txn = 0, ack_total = 0, nbytes = 0, nbits = 0;
  int        stops = 0, viol = 0, txns = 0;
  logic [7:0] cur = '0;
  logic [7:0] byte_log [0:63];
  logic      p_sclk = 1'b1, p_sda = 1'b1, p_oe = 1'b1, p_busy = 1'b0;

  assign sda_in = (!sda_oe && acks_txn == nack_slot) ? 1'b1 : 1'b0;

  always @(negedge clk_25M) begin
    if (busy && !p_busy) begin
      txns++;
      nbits    = 0;
      acks_txn = 0;
    end
    if (sclk && !p_sclk && busy) begin
      if (sda_oe) begin
        cur = {cur[6:0], sda};
        nbits++;
        if (nbits == 8) begin
          byte_log[nbytes[5:0]] = cur;
          nbytes++;
          nbits = 0;
        end
      end else ack_total++;
    end
    if (!sda_oe && p_oe) acks_txn++;
    if (sclk && p_sclk && sda_oe && p_oe && sda != p_sda) begin
      if (!p_sda && sda) stops++;
      else if (!(busy && !p_busy)) viol++;
    end
    p_sclk = sclk;
    p_sda  = sda;
    p_oe   = sda_oe;
    p_busy = busy;
  end

  // hold: 0 = drop req when ack seen, N = drop req after N cycles
  task automatic run_txn(input string nm, input logic [31:0] cfg, input int nslot, input int hold);
    int b0, a0, s0, t0, v0, ack_at, ack_len, busy_at, n, exp_len;
    logic start_ok, nack_done, nack_clr;
    nack_slot = nslot;
    b0 = nbytes; a0 = ack_total; s0 = stops; t0 = txns; v0 = viol;
    ack_at = -1; ack_len = 0; busy_at = -1;
    start_ok = 1'b0; nack_done = 1'b0; nack_clr = 1'b0;
    n = (hold > 600) ? hold + 3 : ACK_CYC + 8;
    @(negedge clk_25M);
    cfg_data = cfg;
    i2c_req  = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_25M);
      if (i == 1) begin
        cfg_data = ~cfg;
        start_ok = sclk && !sda && sda_oe;
        nack_clr = !nack;
      end
      if (busy && busy_at < 0) busy_at = i;
      if (i2c_ack) begin
        if (ack_at < 0) begin
          ack_at    = i;
          nack_done = nack;
          chk({nm, ".busy_in_done"}, busy, 0);
        end
        ack_len++;
      end
      if (hold > 0 && i == hold) i2c_req = 1'b0;
      if (hold == 0 && i2c_ack) i2c_req = 1'b0;
    end
    exp_len = (hold >= ACK_CYC) ? hold - ACK_CYC + 1 : 1;
    chk({nm, ".start_cyc"}, busy_at, 1);
    chk({nm, ".start_lvl"}, start_ok, 1);
    chk({nm, ".nack_clr"}, nack_clr, 1);
    chk({nm, ".ack_cyc"}, ack_at, ACK_CYC);
    chk({nm, ".ack_len"}, ack_len, exp_len);
    chk({nm, ".nbytes"}, nbytes - b0, 4);
    chk({nm, ".byte0"}, byte_log[b0[5:0]], cfg[31:24]);
    chk({nm, ".byte1"}, byte_log[6'(b0 + 1)], cfg[23:16]);
    chk({nm, ".byte2"}, byte_log[6'(b0 + 2)], cfg[15:8]);
    chk({nm, ".byte3"}, byte_log[6'(b0 + 3)], cfg[7:0]);
    chk({nm, ".ack_slots"}, ack_total - a0, 4);
    chk({nm, ".stops"}, stops - s0, 1);
    chk({nm, ".txns"}, txns - t0, 1);
    chk({nm, ".glitch"}, viol - v0, 0);
    chk({nm, ".nack"}, nack_done, (nslot >= 1 && nslot <= 4) ? 1 : 0);
    chk({nm, ".ack_end"}, i2c_ack, 0);
    chk({nm, ".busy_end"}, busy, 0);
  endtask

  initial begin
    int b0, k;
    rst_100   = 1'b0;
    i2c_req   = 1'b0;
    cfg_data  = '0;
    nack_slot = 0;
    repeat (3) @(negedge clk_25M);
    chk("rst.sclk", sclk, 1);
    chk("rst.sda", sda, 1);
    chk("rst.oe", sda_oe, 1);
    chk("rst.ack", i2c_ack, 0);
    chk("rst.busy", busy, 0);
    chk("rst.nack", nack, 0);
    rst_100 = 1'b1;
    repeat (3) @(negedge clk_25M);
    chk("idle.busy", busy, 0);
    chk("idle.sclk", sclk, 1);

    run_txn("basic", 32'h78310311, 0, 0);
    run_txn("nack2", 32'h78310311, 2, 0);
    run_txn("hold",  32'h12345678, 0, 2000);
    run_txn("pulse", 32'hFF00AA55, 0, 1);

    // Abort in the middle of the 3rd byte
    nack_slot = 0;
    b0 = nbytes;
    @(negedge clk_25M);
    cfg_data = 32'hC3C3C3C3;
    i2c_req  = 1'b1;
    k = 0;
    while (nbytes - b0 < 2 && k < 1000) begin
      @(negedge clk_25M);
      k++;
    end
    chk("abort.reach", (k < 1000) ? 1 : 0, 1);
    repeat (7) @(negedge clk_25M);
    #1 rst_100 = 1'b0;
    #1;
    chk("abort.sclk", sclk, 1);
    chk("abort.sda", sda, 1);
    chk("abort.oe", sda_oe, 1);
    chk("abort.busy", busy, 0);
    chk("abort.ack", i2c_ack, 0);
    i2c_req = 1'b0;
    @(negedge clk_25M);
    rst_100 = 1'b1;
    repeat (3) @(negedge clk_25M);
    chk("abort.idle", busy, 0);

    run_txn("fresh", 32'hA5C30F96, 4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_wr_master.md
I2C_WR_MASTER -- requirements
Module: i2c_wr_master

Interface
REQ-001 Parameter QTR_DIV, default 312: clk_25M cycles per SCL quarter-period (SCL ≈ 20.03 kHz); legal range 2..65535.
REQ-002 clk_25M  input  1  system clock; all state on its rising edge, no derived clocks.
REQ-003 rst_100  input  1  reset, asynchronous, active-low.
REQ-004 cfg_data  input  32  write frame: [31:24] device address+W, [23:16] reg addr hi, [15:8] reg addr lo, [7:0] data.
REQ-005 i2c_req  input  1  level request; four-phase handshake with i2c_ack.
REQ-006 i2c_ack  output  1  transaction complete.
REQ-007 sclk  output  1  I2C clock, push-pull.
REQ-008 sda  output  1  I2C data value when sda_oe=1.
REQ-009 sda_oe  output  1  1 = drive sda; 0 = released, for the slave ACK slot.
REQ-010 sda_in  input  1  sampled bus SDA, already synchronised externally.
REQ-011 busy  output  1  high from START through STOP.
REQ-012 nack  output  1  sticky flag: at least one ACK slot read 1 in the last transaction.

Function
REQ-013 The block SHALL use states IDLE, START, BIT, ACKS, STOP and DONE.
REQ-014 Quarter counter: counts 0..QTR_DIV-1 and is cleared on leaving IDLE; a quarter ends when the count reaches QTR_DIV-1.
REQ-015 IDLE: sclk=1, sda=1, sda_oe=1, busy=0.
  - Cycle T0 = i2c_req sampled 1 in IDLE.
  - At T0 the block latches cfg_data into a shift register, clears nack and enters START at T0+1.
REQ-016 START, 2 quarters:
  - q0: sclk=1, sda=0.
  - q1: sclk=0, sda=0.
REQ-017 BIT, 4 quarters per bit, MSB first, shift register bit 31 first:
  - q0: sclk=0, sda=bit.
  - q1 and q2: sclk=1.
  - q3: sclk=0.
  - sda SHALL be stable while sclk=1.
REQ-018 After 8 bits the block SHALL enter ACKS, 4 quarters:
  - sda_oe=0 for all four quarters.
  - sclk follows the same pattern as BIT.
  - sda_in is sampled on the last cycle of q2; a value of 1 sets nack.
  - The transaction continues regardless of the sampled value.
REQ-019 Exactly 4 bytes SHALL be sent, using a 2-bit byte counter and a 3-bit bit counter; after the 4th ACKS the block enters STOP.
REQ-020 STOP, 3 quarters:
  - q0: sclk=0, sda=0.
  - q1: sclk=1, sda=0.
  - q2: sclk=1, sda=1.
REQ-021 Total bus time SHALL be 149*QTR_DIV cycles.
  - DONE is entered at T0+1+149*QTR_DIV.
  - i2c_ack=1 and busy=0 in DONE.
REQ-022 DONE SHALL hold i2c_ack=1 until i2c_req is sampled 0, then return to IDLE with i2c_ack=0 on the next cycle.
REQ-023 If i2c_req is already 0 on DONE entry, i2c_ack SHALL be high for exactly one cycle.
REQ-024 Deassertion of i2c_req during START through STOP SHALL be ignored; the transaction completes.
REQ-025 cfg_data changes after T0 SHALL NOT affect the frame being sent.
REQ-026 A new transaction SHALL start only from IDLE, so i2c_req held high across DONE never retriggers without first going low.
REQ-027 nack SHALL persist until the next T0.

Reset
REQ-028 On rst_100=0 (asynchronous, including mid-transaction) the block SHALL set:
  - state=IDLE, counters=0;
  - sclk=1, sda=1, sda_oe=1;
  - i2c_ack=0, busy=0, nack=0.
REQ-029 After reset release the block SHALL wait in IDLE for i2c_req.
REQ-030 A bus aborted by reset SHALL be left with both lines high, with no STOP generated.

Verification
REQ-031 QTR_DIV=4, cfg_data=0x78310311, slave ACKs 0 -> all of the following:
  - START seen at T0+1.
  - Decoded bytes 78, 31, 03, 11.
  - sda_oe=0 in 4 slots.
  - i2c_ack rises at T0+597.
  - nack=0.
REQ-032 Same frame, sda_in=1 in the 2nd ACK slot -> all 4 bytes sent, STOP issued, nack=1 at DONE; the next transaction clears nack.
REQ-033 i2c_req held high for 2000 cycles with QTR_DIV=4 -> exactly one transaction; i2c_ack stays 1 until req falls, then 0 one cycle later.
REQ-034 i2c_req pulsed for 1 cycle -> full transaction, i2c_ack high exactly 1 cycle.
REQ-035 rst_100 asserted during the 3rd byte -> same cycle: sclk=1, sda=1, sda_oe=1, busy=0; the next req sends a complete fresh frame.
REQ-036 Bus checker throughout all tests -> no sda change while sclk=1 except the START and STOP edges.
